pipeline_scheduler: RTL

PIPELINE_SCHEDULER -- requirements
Module: pipeline_scheduler

---
 rtl/pipeline_scheduler.sv | 75 +++++++
 1 files changed

// File: rtl/pipeline_scheduler.sv
// pipeline_scheduler: two-slot register scoreboard driving freeze/bubble/flush/hold,
// with a RUN/HOLD memory-wait FSM and a saturating stall counter.
module pipeline_scheduler #(
    parameter bit FORWARD_EN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_two_src,
    input  logic        id_wb_en,
    input  logic        id_mem_r_en,
    input  logic [3:0]  id_dest,
    input  logic        exe_b_taken,
    input  logic        mem_busy,
    output logic        freeze,
    output logic        bubble,
    output logic        flush,
    output logic        pipe_hold,
    output logic [15:0] stall_cnt
);
    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       mem_r;
        logic [3:0] dest;
    } slot_t;

    typedef enum logic {RUN, HOLD} state_t;

    state_t      state_q;
    slot_t       exe_q, exe_d, mem_q, mem_d;
    logic [15:0] cnt_q, cnt_d;
    logic        hazard;
    logic        hold_unused;

    function automatic logic hit(input slot_t s, input logic [3:0] a, input logic [3:0] b,
                                 input logic two);
        return s.valid && s.wb_en && (s.dest == a || (two && s.dest == b));
    endfunction

    always_comb begin
        hazard = id_valid && (FORWARD_EN
            ? (exe_q.mem_r && hit(exe_q, id_src1, id_src2, id_two_src))
            : (hit(exe_q, id_src1, id_src2, id_two_src) || hit(mem_q, id_src1, id_src2, id_two_src)));
        pipe_hold = mem_busy;
        freeze    = mem_busy || (!exe_b_taken && hazard);
        flush     = !mem_busy && exe_b_taken;
        bubble    = !mem_busy && (exe_b_taken || hazard);
        mem_d     = mem_busy ? mem_q : exe_q;
        exe_d     = mem_busy ? exe_q
                  : bubble   ? slot_t'('0)
                  : slot_t'{id_valid, id_wb_en, id_mem_r_en, id_dest};
        cnt_d     = ((freeze || pipe_hold) && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    // Controls follow live mem_busy; the FSM only records the memory-wait window.
    assign hold_unused = (state_q == HOLD);
    assign stall_cnt   = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            exe_q   <= '0;
            mem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= mem_busy ? HOLD : RUN;
            exe_q   <= exe_d;
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
